// File: rtl/base_rrpmux_if.sv
// Valid/ready bundle for base_rrpmux: N input ways and one registered output.
// The master drives the inputs and o_r; the slave (the mux) drives i_r and the output stage.
interface base_rrpmux_if #(
   parameter int ways  = 2,
   parameter int width = 1
);
   logic [0:ways-1]       i_v;
   logic [0:ways*width-1] i_d;
   logic [0:ways-1]       i_last;
   logic [0:ways-1]       i_r;
   logic                  o_v;
   logic [0:width-1]      o_d;
   logic                  o_last;
   logic [0:ways-1]       o_sel;
   logic                  o_r;

   modport master (
      output i_v, i_d, i_last, o_r,
      input  i_r, o_v, o_d, o_last, o_sel
   );

   modport slave (
      input  i_v, i_d, i_last, o_r,
      output i_r, o_v, o_d, o_last, o_sel
   );
endinterface

// File: rtl/base_rrpmux.sv
// Round-robin N-way valid/ready mux with a registered output stage.
// Define BASE_RRPMUX_LOCK_EN to hold a multi-beat packet on one way until its last beat.
module base_rrpmux #(
   parameter int ways  = 2,
   parameter int width = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   base_rrpmux_if.slave   bus
);
   localparam int PW = (ways > 1) ? $clog2(ways) : 1;

   logic [PW-1:0]    ptr, g, g_try;
   logic             found, free, xfer;
   logic [0:width-1] d_g;
   logic             last_g;
   logic [0:ways-1]  sel_g, ir;
   int               idx;

   logic             o_v_q, o_last_q;
   logic [0:width-1] o_d_q;
   logic [0:ways-1]  o_sel_q;

`ifdef BASE_RRPMUX_LOCK_EN
   typedef enum logic {UNLOCKED, LOCKED} lock_st_t;
   lock_st_t      lock_st;
   logic [PW-1:0] lock_way;
`endif

   assign free = ~o_v_q | bus.o_r;

   // Scan starts one past the last packet owner, so it gets lowest priority next.
   always_comb begin
      found = 1'b0;
      g     = '0;
      g_try = '0;
      idx   = 0;
      for (int i = 1; i <= ways; i++) begin
         idx = int'(ptr) + i;
         if (idx >= ways) idx = idx - ways;
         g_try = PW'(idx);
         if (!found && bus.i_v[g_try]) begin
            found = 1'b1;
            g     = g_try;
         end
      end
`ifdef BASE_RRPMUX_LOCK_EN
      // Locked way keeps the grant even while it has nothing valid.
      if (lock_st == LOCKED) begin
         found = 1'b1;
         g     = lock_way;
      end
`endif
   end

   always_comb begin
      d_g    = '0;
      last_g = 1'b0;
      sel_g  = '0;
      ir     = '0;
      for (int k = 0; k < ways; k++) begin
         if (g == PW'(k)) begin
            d_g      = bus.i_d[k*width +: width];
            last_g   = bus.i_last[k];
            sel_g[k] = 1'b1;
            ir[k]    = found & free & reset_n;
         end
      end
   end

   assign xfer = found & bus.i_v[g] & free;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         o_v_q    <= 1'b0;
         o_d_q    <= '0;
         o_last_q <= 1'b0;
         o_sel_q  <= '0;
         ptr      <= PW'(ways - 1);
`ifdef BASE_RRPMUX_LOCK_EN
         lock_st  <= UNLOCKED;
         lock_way <= '0;
`endif
      end else if (xfer) begin
         o_v_q    <= 1'b1;
         o_d_q    <= d_g;
         o_last_q <= last_g;
         o_sel_q  <= sel_g;
`ifdef BASE_RRPMUX_LOCK_EN
         if (last_g) begin
            lock_st <= UNLOCKED;
            ptr     <= g;
         end else begin
            lock_st  <= LOCKED;
            lock_way <= g;
         end
`else
         ptr      <= g;
`endif
      end else if (o_v_q && bus.o_r) begin
         o_v_q <= 1'b0;
      end
   end

   assign bus.i_r    = ir;
   assign bus.o_v    = o_v_q;
   assign bus.o_d    = o_d_q;
   assign bus.o_last = o_last_q;
   assign bus.o_sel  = o_sel_q;
endmodule

// File: doc/base_rrpmux.md
Name: base_rrpmux

Overview:
- Round-robin arbitrated N-way valid/ready multiplexer with a registered output stage and optional packet locking.
- Next generation of the priority mux:
  - fair round-robin grant instead of fixed priority;
  - multi-beat packets held on one way until the last beat;
  - output sel/data/last registered for timing closure.
- Sits in front of shared datapath resources (response merge, shared command queue) wherever several streams converge.

Parameters:
- ways, 2, number of input channels (>=2).
- width, 1, data bits per channel.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- i_v  input  [0:ways-1]  per-way valid.
- i_d  input  [0:ways*width-1]  packed data; way k occupies bits [k*width : k*width+width-1].
- i_last  input  [0:ways-1]  per-way last-beat-of-packet flag.
- i_r  output  [0:ways-1]  per-way ready; one-hot or zero.
- o_v  output  1  registered output valid.
- o_d  output  [0:width-1]  registered output data.
- o_last  output  1  registered last flag of the held beat.
- o_sel  output  [0:ways-1]  registered one-hot source way of the held beat.
- o_r  input  1  downstream ready.

Behaviour:
- Reset: clk and reset_n are fixed as one clock, synchronous active-low reset. reset_n low at a rising edge sets:
  - o_v=0, o_d=0, o_last=0, o_sel=0;
  - lock flag=0;
  - round-robin pointer ptr=ways-1, so way 0 has first priority.
- Reset mid-operation: the held beat is discarded and the lock is released at that edge. i_r is all-zero while reset_n is low.
- Output stage:
  - free = ~o_v | o_r. Single register, full throughput: one beat per cycle when o_r stays high.
  - Latency: an input accepted at edge n appears on o_v/o_d at edge n (visible in cycle n+1).
- Grant, combinational from i_v, ptr and lock:
  - Unlocked: g = first k with i_v[k]=1, scanning ptr+1, ptr+2, ... mod ways (wrap-around).
  - Locked: g = lock_way regardless of other valids.
  - i_r[g] = free; every other i_r = 0.
  - i_r is not gated by i_v[g]. When nothing is valid, i_r=0.
  - Combinational path o_r -> i_r is permitted.
- Transfer: i_v[g] & i_r[g] at an edge. Registers load o_d=i_d[g], o_last=i_last[g], o_sel=onehot(g), o_v=1.
- No transfer: if o_v & o_r, then o_v<=0. o_d, o_last and o_sel are then don't-care but are held.
- Stall: if o_v & ~o_r, all output registers hold and i_r=0.
- Lock FSM, two states, UNLOCKED and LOCKED(lock_way):
  - UNLOCKED -> LOCKED(g) on transfer with i_last[g]=0.
  - LOCKED -> UNLOCKED on transfer with i_last[lock_way]=1.
  - A single-beat packet (i_last=1) never locks.
- Locked way deasserts i_v mid-packet: the lock persists and no other way is granted (no bubbles are filled by other ways).
- Pointer: ptr<=g on every transfer that ends a packet (i_last[g]=1). Transfers that do not end a packet leave ptr unchanged.
- Simultaneous requests: exactly one way is granted per cycle. A way that just finished a packet has lowest priority next.
- Data of non-granted ways is ignored. i_d/i_last are sampled only on transfer.

Optional Feature:
- Macro: BASE_RRPMUX_LOCK_EN.
- Defined: packet locking exactly as described above.
- Undefined:
  - no lock FSM; every beat is arbitrated independently;
  - ptr updates on every transfer;
  - i_last is passed through to o_last only, with no effect on arbitration.

Test Plan (ways=4, width=8):
- Reset: hold reset_n=0 for 2 clocks with i_v=4'b1111 -> i_r=0000, o_v=0, o_d=8'h00, o_sel=0000. After release, the first transfer is way 0.
- Fairness: i_v=1111, all i_last=1, o_r=1, data k=8'hA0+k -> o_d sequence A0,A1,A2,A3,A0,... on consecutive cycles; o_sel cycles 1000,0100,0010,0001.
- Locking (LOCK_EN): way 2 sends 3 beats 8'h20,21,22 with i_last 0,0,1; way 1 is valid throughout.
  - Expect o_d 20,21,22 before any way-1 beat.
  - Drop i_v[2] for 2 cycles mid-packet -> i_r[1] stays 0 and o_v goes low.
  - Then way 3 is granted before way 1 (scan from ptr=2).
- Backpressure: o_r=0 for 3 cycles with o_v=1, o_d=8'h55 -> o_d/o_sel stable, i_r=0000. Raising o_r -> the next beat loads the same edge with no bubble.
- Wrap-around: ptr=3, i_v=0101 -> grant way 1. Then i_v=1000 only -> grant way 0.
- Reset mid-packet (LOCK_EN): way 0 locked after beat with i_last=0, then reset_n=0 for 1 clock -> o_v=0, lock cleared. Next grant with i_v=0110 is way 1.
